ram_bist_ctrl: RTL and testbench

- Initiator that drives the single-port 32x8 synchronous RAM (clk, wena, addr, datain, dataout) on its bus side.
- On a start pulse it writes an address-derived pattern to every location, reads every location back, and compares each word.
- Reports pass/fail, the first failing address and data, and an error count.
- Replaces hand-written testbench stimulus for on-chip RAM self-test in the lab designs.

---
 rtl/ram_bist_ctrl.sv | 172 +++++++++++++++++
 tb/tb_ram_bist_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_bist_ctrl.sv
// rtl/ram_bist_ctrl.sv - write/read-back self-test initiator for a single-port synchronous RAM
module ram_bist_ctrl #(
   parameter int                ADDR_W = 5,
   parameter int                DATA_W = 8,
   parameter int                RD_LAT = 1,
   parameter logic [DATA_W-1:0] SEED   = 8'hA5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [ADDR_W:0]   err_cnt,
   output logic [ADDR_W-1:0] fail_addr,
   output logic [DATA_W-1:0] fail_data,
   output logic              wena,
   output logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] datain,
   input  logic [DATA_W-1:0] dataout
);

   localparam int              DEPTH     = 2**ADDR_W;
   localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W:0]   ERR_MAX   = (ADDR_W+1)'(DEPTH);
   localparam logic [2:0]        DRN_LAST  = 3'(RD_LAT - 1);

   typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

   state_t              state, state_n;
   logic                wena_n, done_n, pass_n;
   logic [ADDR_W-1:0]   addr_n, fail_addr_n;
   logic [DATA_W-1:0]   datain_n, fail_data_n;
   logic [ADDR_W:0]     err_cnt_n;
   logic [2:0]          dcnt, dcnt_n;
   logic [RD_LAT-1:0]   pv, pv_n;
   logic [ADDR_W-1:0]   pa [RD_LAT];
   logic [ADDR_W-1:0]   pa_n [RD_LAT];
   logic                issue, cmp, mism;

   // Pattern: seed XOR the address bits repeated out to the data width
   function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a);
      logic [DATA_W-1:0] r;
      r = '0;
      for (int i = 0; i < DATA_W; i++) r[i] = a[i % ADDR_W];
      return r ^ SEED;
   endfunction

   assign busy = (state != IDLE);

   always_comb begin
      state_n     = state;
      wena_n      = 1'b0;
      addr_n      = addr;
      datain_n    = datain;
      done_n      = 1'b0;
      pass_n      = pass;
      err_cnt_n   = err_cnt;
      fail_addr_n = fail_addr;
      fail_data_n = fail_data;
      dcnt_n      = dcnt;
      issue       = 1'b0;
      pv_n        = pv;
      pa_n        = pa;

      // Tail of the tag pipe lines up with dataout for the read it tags
      cmp  = pv[RD_LAT-1] && !abort && (state == READ || state == DRAIN);
      mism = cmp && (dataout != pat(pa[RD_LAT-1]));
      if (mism) begin
         if (err_cnt == '0) begin
            fail_addr_n = pa[RD_LAT-1];
            fail_data_n = dataout;
         end
         if (err_cnt != ERR_MAX) err_cnt_n = err_cnt + 1'b1;
      end

      case (state)
         IDLE: begin
            addr_n = '0;
            // done high means this is the exit cycle of DRAIN; hold off one cycle
            if (start && !abort && !done) begin
               state_n     = WRITE;
               wena_n      = 1'b1;
               datain_n    = pat('0);
               err_cnt_n   = '0;
               fail_addr_n = '0;
               fail_data_n = '0;
               pass_n      = 1'b0;
            end
         end
         WRITE: begin
            if (addr == ADDR_LAST) begin
               state_n = READ;
               addr_n  = '0;
            end else begin
               wena_n   = 1'b1;
               addr_n   = addr + ADDR_W'(1);
               datain_n = pat(addr + ADDR_W'(1));
            end
         end
         READ: begin
            issue = 1'b1;
            if (addr == ADDR_LAST) begin
               state_n = DRAIN;
               addr_n  = '0;
               dcnt_n  = '0;
            end else begin
               addr_n = addr + ADDR_W'(1);
            end
         end
         DRAIN: begin
            addr_n = '0;
            if (dcnt == DRN_LAST) begin
               state_n = IDLE;
               done_n  = 1'b1;
               pass_n  = (err_cnt_n == '0);
            end else begin
               dcnt_n = dcnt + 3'd1;
            end
         end
         default: state_n = IDLE;
      endcase

      pv_n[0] = issue;
      pa_n[0] = addr;
      for (int i = 1; i < RD_LAT; i++) begin
         pv_n[i] = pv[i-1];
         pa_n[i] = pa[i-1];
      end

      if (abort && state != IDLE) begin
         state_n = IDLE;
         wena_n  = 1'b0;
         addr_n  = '0;
         done_n  = 1'b0;
         pass_n  = pass;
         pv_n    = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         wena      <= 1'b0;
         addr      <= '0;
         datain    <= '0;
         done      <= 1'b0;
         pass      <= 1'b0;
         err_cnt   <= '0;
         fail_addr <= '0;
         fail_data <= '0;
         dcnt      <= '0;
         pv        <= '0;
         pa        <= '{default: '0};
      end else begin
         state     <= state_n;
         wena      <= wena_n;
         addr      <= addr_n;
         datain    <= datain_n;
         done      <= done_n;
         pass      <= pass_n;
         err_cnt   <= err_cnt_n;
         fail_addr <= fail_addr_n;
         fail_data <= fail_data_n;
         dcnt      <= dcnt_n;
         pv        <= pv_n;
         pa        <= pa_n;
      end
   end

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// tb/tb_ram_bist_ctrl.sv - self-checking bench for ram_bist_ctrl with RAM models at read latency 1 and 3
module tb_ram_bist_ctrl;

   logic clk = 1'b0;
   logic rst_n, start, abort;
   int   cur;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;

   logic       busy1, done1, pass1, wena1, busy3, done3, pass3, wena3;
   logic [5:0] err1, err3;
   logic [4:0] fa1, fa3, addr1, addr3;
   logic [7:0] fd1, fd3, din1, din3, dout1, dout3;

   logic       busy, done, pass, wena;
   logic [5:0] err_cnt;
   logic [4:0] fail_addr, addr;
   logic [7:0] fail_data, datain;

   logic [7:0] mem1 [32];
   logic [7:0] mem3 [32];
   logic [7:0] f_or [32];
   logic [7:0] f_xor [32];
   logic [7:0] q1;
   logic [7:0] q3 [3];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   ram_bist_ctrl #(.ADDR_W(5), .DATA_W(8), .RD_LAT(1), .SEED(8'hA5)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start && cur == 1), .abort(abort && cur == 1),
      .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1), .fail_addr(fa1),
      .fail_data(fd1), .wena(wena1), .addr(addr1), .datain(din1), .dataout(dout1));

   ram_bist_ctrl #(.ADDR_W(5), .DATA_W(8), .RD_LAT(3), .SEED(8'hA5)) dut3 (
      .clk(clk), .rst_n(rst_n), .start(start && cur == 3), .abort(abort && cur == 3),
      .busy(busy3), .done(done3), .pass(pass3), .err_cnt(err3), .fail_addr(fa3),
      .fail_data(fd3), .wena(wena3), .addr(addr3), .datain(din3), .dataout(dout3));

   assign busy      = (cur == 3) ? busy3 : busy1;
   assign done      = (cur == 3) ? done3 : done1;
   assign pass      = (cur == 3) ? pass3 : pass1;
   assign wena      = (cur == 3) ? wena3 : wena1;
   assign err_cnt   = (cur == 3) ? err3  : err1;
   assign fail_addr = (cur == 3) ? fa3   : fa1;
   assign fail_data = (cur == 3) ? fd3   : fd1;
   assign addr      = (cur == 3) ? addr3 : addr1;
   assign datain    = (cur == 3) ? din3  : din1;

   // RAM models: faults are applied on the read path only
   always @(posedge clk) begin
      if (wena1) mem1[addr1] <= din1;
      q1 <= (mem1[addr1] | f_or[addr1]) ^ f_xor[addr1];
      if (wena3) mem3[addr3] <= din3;
      q3[0] <= (mem3[addr3] | f_or[addr3]) ^ f_xor[addr3];
      q3[1] <= q3[0];
      q3[2] <= q3[1];
   end
   assign dout1 = q1;
   assign dout3 = q3[2];

   function automatic logic [7:0] tb_pat(input int a);
      return 8'(((a * 33) & 255) ^ 165);
   endfunction

   task automatic clear_faults();
      for (int i = 0; i < 32; i++) begin
         f_or[i]  = 8'h00;
         f_xor[i] = 8'h00;
      end
   endtask

   task automatic run_full(input int lat, input bit hold_start);
      int S, wr_bad, rd_bad, t, dcyc, exp_err, exp_fa;
      logic [7:0] exp_fd, rv;
      bit got_done;
      exp_err = 0; exp_fa = 0; exp_fd = 8'h00;
      for (int a = 0; a < 32; a++) begin
         rv = (tb_pat(a) | f_or[a]) ^ f_xor[a];
         if (rv != tb_pat(a)) begin
            if (exp_err == 0) begin exp_fa = a; exp_fd = rv; end
            exp_err++;
         end
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      start = 1'b1; S = cyc;
      @(negedge clk); start = 1'b0;
      n_cmp++;
      if (err_cnt !== 6'd0 || pass !== 1'b0 || fail_addr !== 5'd0) begin
         n_bad++; $display("FAIL start_clear: err=%0d pass=%0b fa=%0d want 0/0/0", err_cnt, pass, fail_addr);
      end
      wr_bad = 0; rd_bad = 0;
      for (int k = 0; k < 32; k++) begin
         if (k > 0) @(negedge clk);
         if (!(wena === 1'b1 && addr === 5'(k) && datain === tb_pat(k) && busy === 1'b1)) wr_bad++;
         if (k == 1) begin
            n_cmp++;
            if (datain !== 8'h84 || addr !== 5'd1 || cyc != S + 2) begin
               n_bad++; $display("FAIL write_s2: addr=%0d datain=%0h cyc=%0d want 1/84/%0d", addr, datain, cyc, S + 2);
            end
         end
      end
      for (int k = 0; k < 32; k++) begin
         @(negedge clk);
         if (!(wena === 1'b0 && addr === 5'(k) && busy === 1'b1)) rd_bad++;
      end
      n_cmp++;
      if (wr_bad != 0) begin n_bad++; $display("FAIL write_phase: bad cycles got %0d want 0", wr_bad); end
      n_cmp++;
      if (rd_bad != 0) begin n_bad++; $display("FAIL read_phase: bad cycles got %0d want 0", rd_bad); end
      t = 0; got_done = 0; dcyc = 0;
      while (t < 20 && !got_done) begin
         @(negedge clk); t++;
         if (done === 1'b1) begin got_done = 1; dcyc = cyc; end
      end
      n_cmp++;
      if (!got_done || dcyc != S + 64 + lat + 1) begin
         n_bad++; $display("FAIL done_time: got cycle %0d (seen=%0b) want %0d", dcyc, got_done, S + 64 + lat + 1);
      end
      n_cmp++;
      if (pass !== (exp_err == 0)) begin n_bad++; $display("FAIL pass: got %0b want %0b", pass, exp_err == 0); end
      n_cmp++;
      if (err_cnt !== 6'(exp_err)) begin n_bad++; $display("FAIL err_cnt: got %0d want %0d", err_cnt, exp_err); end
      n_cmp++;
      if (fail_addr !== 5'(exp_fa)) begin n_bad++; $display("FAIL fail_addr: got %0d want %0d", fail_addr, exp_fa); end
      n_cmp++;
      if (fail_data !== exp_fd) begin n_bad++; $display("FAIL fail_data: got %0h want %0h", fail_data, exp_fd); end
      if (hold_start) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n_cmp++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         n_bad++; $display("FAIL done_one_cycle: done=%0b busy=%0b want 0/0", done, busy);
      end
   endtask

   task automatic test_reset();
      int S, bad;
      rst_n = 1'b1; start = 1'b0; abort = 1'b0; cur = 1;
      clear_faults();
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({busy1, done1, pass1, err1, fa1, fd1, wena1, addr1, din1} !== '0 ||
          {busy3, done3, pass3, err3, fa3, fd3, wena3, addr3, din3} !== '0) begin
         n_bad++; $display("FAIL reset_power_on: outputs not all zero");
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      f_xor[1] = 8'h40;
      @(negedge clk); start = 1'b1; S = cyc;
      @(negedge clk); start = 1'b0;
      while (cyc < S + 40) @(negedge clk);
      n_cmp++;
      if (err_cnt !== 6'd1 || busy !== 1'b1) begin
         n_bad++; $display("FAIL reset_prerun: err=%0d busy=%0b want 1/1", err_cnt, busy);
      end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({busy, done, pass, err_cnt, fail_addr, fail_data, wena, addr, datain} !== '0) begin
         n_bad++; $display("FAIL reset_midrun: busy=%0b err=%0d fa=%0d fd=%0h wena=%0b addr=%0d want all 0",
                           busy, err_cnt, fail_addr, fail_data, wena, addr);
      end
      @(negedge clk); rst_n = 1'b1;
      bad = 0;
      repeat (40) begin @(negedge clk); if (wena !== 1'b0 || busy !== 1'b0) bad++; end
      n_cmp++;
      if (bad != 0) begin n_bad++; $display("FAIL reset_quiet: active cycles got %0d want 0", bad); end
      clear_faults();
   endtask

   task automatic test_clean_run();
      cur = 1; clear_faults();
      run_full(1, 0);
   endtask

   task automatic test_single_fault();
      cur = 1; clear_faults();
      f_or[3] = 8'h01;
      run_full(1, 0);
      n_cmp++;
      if (fail_data !== 8'hC7 || fail_addr !== 5'd3) begin
         n_bad++; $display("FAIL single_fault_const: fa=%0d fd=%0h want 3/c7", fail_addr, fail_data);
      end
   endtask

   task automatic test_back_to_back();
      cur = 1; clear_faults();
      f_xor[5] = 8'h01; f_xor[9] = 8'h80; f_xor[31] = 8'hFF;
      run_full(1, 1);
      clear_faults();
      run_full(1, 0);
   endtask

   task automatic test_abort();
      int S, bad;
      cur = 1; clear_faults();
      f_xor[2] = 8'h10; f_xor[20] = 8'h01;
      @(negedge clk); start = 1'b1; S = cyc;
      @(negedge clk); start = 1'b0;
      while (cyc < S + 10) @(negedge clk);
      start = 1'b1;
      @(negedge clk); start = 1'b0;
      n_cmp++;
      if (addr !== 5'd10 || wena !== 1'b1) begin
         n_bad++; $display("FAIL busy_start: addr=%0d wena=%0b want 10/1", addr, wena);
      end
      while (cyc < S + 40) @(negedge clk);
      abort = 1'b1;
      @(negedge clk); abort = 1'b0;
      n_cmp++;
      if (busy !== 1'b0 || wena !== 1'b0 || done !== 1'b0) begin
         n_bad++; $display("FAIL abort_idle: busy=%0b wena=%0b done=%0b want 0/0/0", busy, wena, done);
      end
      n_cmp++;
      if (err_cnt !== 6'd1 || fail_addr !== 5'd2 || fail_data !== (tb_pat(2) ^ 8'h10) || pass !== 1'b0) begin
         n_bad++; $display("FAIL abort_partial: err=%0d fa=%0d fd=%0h pass=%0b want 1/2/%0h/0",
                           err_cnt, fail_addr, fail_data, pass, tb_pat(2) ^ 8'h10);
      end
      bad = 0;
      repeat (80) begin @(negedge clk); if (wena !== 1'b0 || done !== 1'b0 || busy !== 1'b0) bad++; end
      n_cmp++;
      if (bad != 0) begin n_bad++; $display("FAIL abort_quiet: active cycles got %0d want 0", bad); end
      start = 1'b1; abort = 1'b1;
      @(negedge clk); start = 1'b0; abort = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (busy !== 1'b0 || wena !== 1'b0) begin
         n_bad++; $display("FAIL abort_beats_start: busy=%0b wena=%0b want 0/0", busy, wena);
      end
      clear_faults();
   endtask

   task automatic test_random_faults();
      int n, a;
      cur = 1;
      for (int it = 0; it < 6; it++) begin
         clear_faults();
         n = $urandom_range(0, 4);
         for (int j = 0; j < n; j++) begin
            a = $urandom_range(0, 31);
            f_xor[a] = 8'($urandom_range(1, 255));
         end
         if (it == 5) for (int j = 0; j < 32; j++) f_or[j] = 8'hFF;
         if (it == 4) for (int j = 0; j < 32; j++) f_xor[j] = 8'($urandom_range(1, 255));
         run_full(1, 0);
      end
      clear_faults();
   endtask

   task automatic test_latency();
      int a;
      cur = 3;
      for (int it = 0; it < 3; it++) begin
         clear_faults();
         f_xor[0] = 8'($urandom_range(1, 255));
         a = $urandom_range(1, 31);
         if (it > 0) f_xor[a] = 8'($urandom_range(1, 255));
         run_full(3, 0);
      end
      clear_faults();
      run_full(3, 0);
      cur = 1;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_clean_run();
      test_single_fault();
      test_back_to_back();
      test_abort();
      test_random_faults();
      test_latency();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
